// File: rtl/cadr_dbg_pkg.sv
// Shared constants and types for the CADR debug/trace monitor.
// The optional trace freeze is selected with the CADR_TRACE_FREEZE_EN macro.
package cadr_dbg_pkg;

  // CPU state encoding for the instruction-fetch state.
  localparam logic [5:0] FETCH_STATE = 6'b000001;
  localparam int         MAX_NWATCH  = 8;

  localparam int PC_W_DEF = 14;
  localparam int IR_W_DEF = 49;

  typedef struct packed {
    logic [PC_W_DEF-1:0] pc;
    logic [IR_W_DEF-1:0] ir;
  } trace_entry_t;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } mon_state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/cadr_trace_monitor_if.sv
// Fetch-sample and trace read-back bus between the CPU/host side and the
// trace monitor.
interface cadr_trace_monitor_if #(
  parameter int PC_W  = 14,
  parameter int IR_W  = 49,
  parameter int DEPTH = 16
);
  localparam int AW = $clog2(DEPTH);

  logic            fetch;
  logic [PC_W-1:0] lpc;
  logic [IR_W-1:0] ir;
  logic [AW-1:0]   rd_idx;
  logic            rd_valid;
  logic [PC_W-1:0] rd_pc;
  logic [IR_W-1:0] rd_ir;

  modport master (output fetch, lpc, ir, rd_idx, input rd_valid, rd_pc, rd_ir);
  modport slave  (input fetch, lpc, ir, rd_idx, output rd_valid, rd_pc, rd_ir);
endinterface

// File: rtl/cadr_trace_ram.sv
// Simple dual-port trace storage: one write port, one synchronous read port
// that returns the previous contents when both ports hit the same address.
module cadr_trace_ram #(
  parameter int DEPTH = 16,
  parameter int W     = 63
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [W-1:0]             wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [W-1:0]             rdata_o
);
  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] rdata_q;

  // NOTE: the array is deliberately not reset so it maps onto RAM primitives;
  // validity of its contents is tracked by the entry count outside.
  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/cadr_trace_monitor.sv
// CADR execution monitor: fetch trace ring buffer, fetch/watch counters, halt latch.
// Define CADR_TRACE_FREEZE_EN to freeze trace recording once halted.
module cadr_trace_monitor
  import cadr_dbg_pkg::*;
#(
  parameter int PC_W        = PC_W_DEF,
  parameter int IR_W        = IR_W_DEF,
  parameter int DEPTH       = 16,
  parameter int NWATCH      = 2,
  parameter int FAULT_LIMIT = 6,
  parameter int CYC_W       = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  cadr_trace_monitor_if.slave      bus,
  input  logic [NWATCH*PC_W-1:0]   watch_pc,
  input  logic [NWATCH-1:0]        watch_en,
  input  logic                     clear,
  output logic [$clog2(DEPTH):0]   entries,
  output logic [7:0]               fault_count,
  output logic [CYC_W-1:0]         cycle_count,
  output logic [NWATCH-1:0]        watch_hit,
  output logic                     halt
);
  localparam int         AW   = $clog2(DEPTH);
  localparam int         EW   = PC_W + IR_W;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  mon_state_e        state_q, state_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW:0]       entries_q, entries_d;
  logic [7:0]        fault_q, fault_d;
  logic [CYC_W-1:0]  cyc_q, cyc_d;
  logic [NWATCH-1:0] hit_q, hit_d;
  logic [NWATCH-1:0] hit_vec;
  logic              rd_valid_q;
  logic              rec_en;
  logic              soft_rst;
  logic [AW-1:0]     rd_addr;
  logic [EW-1:0]     ram_rdata;

  assign soft_rst = reset | clear;

`ifdef CADR_TRACE_FREEZE_EN
  assign rec_en = bus.fetch & (state_q == RUN);
`else
  assign rec_en = bus.fetch;
`endif

  // Once the ring is full the oldest entry sits at the write pointer.
  assign rd_addr = ((entries_q == FULL) ? wr_ptr_q : '0) + bus.rd_idx;

  cadr_trace_ram #(.DEPTH(DEPTH), .W(EW)) u_ram (
    .clk     (clk),
    .we_i    (rec_en & ~soft_rst),
    .waddr_i (wr_ptr_q),
    .wdata_i ({bus.lpc, bus.ir}),
    .raddr_i (rd_addr),
    .rdata_o (ram_rdata)
  );

  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    hit_vec   = '0;
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    entries_d = entries_q;
    fault_d   = fault_q;
    cyc_d     = cyc_q;
    for (int k = 0; k < NWATCH; k++) begin
      hit_vec[k] = bus.fetch & watch_en[k] & (bus.lpc == watch_pc[k*PC_W +: PC_W]);
    end
    hit_d = hit_q | hit_vec;

    if (rec_en) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
      if (entries_q != FULL) entries_d = entries_q + (AW+1)'(1);
    end
    if (bus.fetch && (cyc_q != '1)) cyc_d = cyc_q + CYC_W'(1);
    // Several slots matching on one fetch still count as a single fault.
    if (|hit_vec) fault_d = sat_inc8(fault_q);

    case (state_q)
      RUN:     if ((|hit_vec) && (int'(fault_d) >= FAULT_LIMIT)) state_d = HALTED;
      HALTED:  state_d = HALTED;
      default: state_d = RUN;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (soft_rst) begin
      state_q    <= RUN;
      wr_ptr_q   <= '0;
      entries_q  <= '0;
      fault_q    <= '0;
      cyc_q      <= '0;
      hit_q      <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      entries_q  <= entries_d;
      fault_q    <= fault_d;
      cyc_q      <= cyc_d;
      hit_q      <= hit_d;
      rd_valid_q <= ({1'b0, bus.rd_idx} < entries_q);
    end
  end

  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_pc    = rd_valid_q ? ram_rdata[EW-1:IR_W] : '0;
  assign bus.rd_ir    = rd_valid_q ? ram_rdata[IR_W-1:0]  : '0;
  assign entries      = entries_q;
  assign fault_count  = fault_q;
  assign cycle_count  = cyc_q;
  assign watch_hit    = hit_q;
  assign halt         = (state_q == HALTED);
endmodule

// File: tb/tb_cadr_trace_monitor.sv
// Bench for cadr_trace_monitor: directed scenarios then random fetch traffic,
// checked against a queue-based trace model.
module tb_cadr_trace_monitor;
  import cadr_dbg_pkg::*;

  localparam int PC_W        = PC_W_DEF;
  localparam int IR_W        = IR_W_DEF;
  localparam int DEPTH       = 16;
  localparam int NWATCH      = 2;
  localparam int FAULT_LIMIT = 6;
  localparam int CYC_W       = 32;
  localparam int AW          = $clog2(DEPTH);
`ifdef CADR_TRACE_FREEZE_EN
  localparam bit FREEZE = 1'b1;
`else
  localparam bit FREEZE = 1'b0;
`endif
  localparam logic [5:0] IDLE_STATE = 6'b000010;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   clear;
  logic [NWATCH*PC_W-1:0] watch_pc;
  logic [NWATCH-1:0]      watch_en;
  logic [AW:0]            entries;
  logic [7:0]             fault_count;
  logic [CYC_W-1:0]       cycle_count;
  logic [NWATCH-1:0]      watch_hit;
  logic                   halt;
  logic [5:0]             cpu_state;

  always #5 clk = ~clk;

  cadr_trace_monitor_if #(.PC_W(PC_W), .IR_W(IR_W), .DEPTH(DEPTH)) bus_if ();

  assign bus_if.fetch = (cpu_state == FETCH_STATE);

  cadr_trace_monitor #(
    .PC_W(PC_W), .IR_W(IR_W), .DEPTH(DEPTH), .NWATCH(NWATCH),
    .FAULT_LIMIT(FAULT_LIMIT), .CYC_W(CYC_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus_if),
    .watch_pc    (watch_pc),
    .watch_en    (watch_en),
    .clear       (clear),
    .entries     (entries),
    .fault_count (fault_count),
    .cycle_count (cycle_count),
    .watch_hit   (watch_hit),
    .halt        (halt)
  );

  // Reference model: the trace is a queue of at most DEPTH entries, oldest first.
  trace_entry_t      m_tr[$];
  longint            m_cyc;
  int                m_flt;
  logic [NWATCH-1:0] m_hit;
  bit                m_halt;
  logic              m_rv;
  logic [PC_W-1:0]   m_rpc;
  logic [IR_W-1:0]   m_rir;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_tr.delete();
    m_cyc  = 0;
    m_flt  = 0;
    m_hit  = '0;
    m_halt = 1'b0;
    m_rv   = 1'b0;
    m_rpc  = '0;
    m_rir  = '0;
  endfunction

  function automatic logic [IR_W-1:0] rand_ir();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[IR_W-1:0];
  endfunction

  task automatic check_all(input string tag);
    check({tag, "_entries"}, 64'(entries), 64'(m_tr.size()));
    check({tag, "_cycles"},  64'(cycle_count), 64'(m_cyc));
    check({tag, "_faults"},  64'(fault_count), 64'(m_flt));
    check({tag, "_whit"},    64'(watch_hit), 64'(m_hit));
    check({tag, "_halt"},    64'(halt), 64'(m_halt));
    check({tag, "_rvalid"},  64'(bus_if.rd_valid), 64'(m_rv));
    check({tag, "_rpc"},     64'(bus_if.rd_pc), 64'(m_rpc));
    check({tag, "_rir"},     64'(bus_if.rd_ir), 64'(m_rir));
  endtask

  task automatic do_reset(input string tag);
    reset     = 1'b1;
    clear     = 1'b0;
    cpu_state = IDLE_STATE;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    check_all(tag);
  endtask

  // One clock: apply inputs, advance, update the model, compare everything.
  task automatic cycle(input bit f, input logic [PC_W-1:0] pc, input logic [IR_W-1:0] ir,
                       input bit clr, input logic [AW-1:0] idx, input string tag);
    bit any;
    bit blocked;
    trace_entry_t e;
    cpu_state     = f ? FETCH_STATE : IDLE_STATE;
    bus_if.lpc    = pc;
    bus_if.ir     = ir;
    bus_if.rd_idx = idx;
    clear         = clr;
    if (!clr && (int'(idx) < m_tr.size())) begin
      m_rv  = 1'b1;
      m_rpc = m_tr[idx].pc;
      m_rir = m_tr[idx].ir;
    end else begin
      m_rv  = 1'b0;
      m_rpc = '0;
      m_rir = '0;
    end
    @(posedge clk); #1;
    if (clr) begin
      model_reset();
    end else if (f) begin
      if (m_cyc < ((64'd1 << CYC_W) - 1)) m_cyc++;
      any = 1'b0;
      for (int k = 0; k < NWATCH; k++) begin
        if (watch_en[k] && (pc == watch_pc[k*PC_W +: PC_W])) begin
          m_hit[k] = 1'b1;
          any      = 1'b1;
        end
      end
      blocked = FREEZE && m_halt;
      if (!blocked) begin
        e.pc = pc;
        e.ir = ir;
        m_tr.push_back(e);
        if (m_tr.size() > DEPTH) void'(m_tr.pop_front());
      end
      if (any) begin
        if (m_flt < 255) m_flt++;
        if (m_flt >= FAULT_LIMIT) m_halt = 1'b1;
      end
    end
    clear     = 1'b0;
    cpu_state = IDLE_STATE;
    check_all(tag);
  endtask

  initial begin
    int e0;
    longint c0;
    reset         = 1'b1;
    clear         = 1'b0;
    cpu_state     = IDLE_STATE;
    bus_if.lpc    = '0;
    bus_if.ir     = '0;
    bus_if.rd_idx = '0;
    watch_pc      = '0;
    watch_en      = '0;
    do_reset("reset");

    // Five fetches, read oldest and an out-of-range index.
    for (int i = 0; i < 5; i++) cycle(1'b1, PC_W'(14'o100 + i), rand_ir(), 1'b0, '0, "t1_f");
    check("t1_entries", 64'(entries), 64'd5);
    check("t1_cycles", 64'(cycle_count), 64'd5);
    cycle(1'b0, '0, '0, 1'b0, AW'(0), "t1_rd0");
    check("t1_rd_pc0", 64'(bus_if.rd_pc), 64'(14'o100));
    cycle(1'b0, '0, '0, 1'b0, AW'(5), "t1_rd5");
    check("t1_rd_valid5", 64'(bus_if.rd_valid), 64'd0);

    // Wrap-around: 20 fetches into 16 entries.
    do_reset("t2_reset");
    for (int i = 1; i <= 20; i++) cycle(1'b1, PC_W'(i), rand_ir(), 1'b0, '0, "t2_f");
    check("t2_entries", 64'(entries), 64'd16);
    cycle(1'b0, '0, '0, 1'b0, AW'(0), "t2_rd0");
    check("t2_rd_pc0", 64'(bus_if.rd_pc), 64'd5);
    cycle(1'b0, '0, '0, 1'b0, AW'(15), "t2_rd15");
    check("t2_rd_pc15", 64'(bus_if.rd_pc), 64'd20);

    // Six watch hits interleaved with misses reach the halt limit.
    do_reset("t3_reset");
    watch_pc[PC_W-1:0] = 14'o26;
    watch_en           = 2'b01;
    for (int i = 1; i <= 6; i++) begin
      cycle(1'b1, 14'o30, rand_ir(), 1'b0, '0, "t3_miss");
      cycle(1'b1, 14'o26, rand_ir(), 1'b0, '0, "t3_hit");
      if (i == 5) check("t3_halt_before", 64'(halt), 64'd0);
    end
    check("t3_halt", 64'(halt), 64'd1);
    check("t3_faults", 64'(fault_count), 64'd6);
    check("t3_whit", 64'(watch_hit), 64'(2'b01));

    // Fetches after halt: counters advance, trace freezes only in the freeze build.
    e0 = int'(entries);
    c0 = longint'(cycle_count);
    for (int i = 0; i < 3; i++) cycle(1'b1, PC_W'(14'o40 + i), rand_ir(), 1'b0, '0, "t5_f");
    check("t5_entries", 64'(entries), FREEZE ? 64'(e0) : 64'((e0 + 3 > DEPTH) ? DEPTH : e0 + 3));
    check("t5_cycles", 64'(cycle_count), 64'(c0 + 3));
    check("t5_halt", 64'(halt), 64'd1);

    // Clear wins over a simultaneous fetch at a watch PC.
    cycle(1'b1, 14'o26, rand_ir(), 1'b1, '0, "t6_clr");
    check("t6_halt", 64'(halt), 64'd0);
    check("t6_entries", 64'(entries), 64'd0);
    check("t6_faults", 64'(fault_count), 64'd0);
    check("t6_cycles", 64'(cycle_count), 64'd0);
    check("t6_whit", 64'(watch_hit), 64'd0);

    // Both slots on the same PC: one fault, both flags.
    do_reset("t4_reset");
    watch_pc = {14'o26, 14'o26};
    watch_en = 2'b11;
    cycle(1'b1, 14'o26, rand_ir(), 1'b0, '0, "t4_hit");
    check("t4_faults", 64'(fault_count), 64'd1);
    check("t4_whit", 64'(watch_hit), 64'(2'b11));

    // Random traffic over a small PC range so hits, halts and collisions occur.
    do_reset("rnd_reset");
    for (int r = 0; r < 600; r++) begin
      if (r % 100 == 0) begin
        watch_pc = {PC_W'($urandom_range(0, 7)), PC_W'($urandom_range(0, 7))};
        watch_en = NWATCH'($urandom_range(0, 3));
      end
      cycle($urandom_range(0, 3) != 0, PC_W'($urandom_range(0, 7)), rand_ir(),
            $urandom_range(0, 59) == 0, AW'($urandom_range(0, DEPTH - 1)), "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
